// File: rtl/wb_pkg.sv
// Shared widths, depth and the buffered write-back entry type for the
// reg_writeback block.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int WB_DEPTH = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// ALU and load result channels feeding the write-back stage; the producer
// side uses the master modport, reg_writeback uses the slave modport.
interface reg_writeback_if #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries with two ordered push ports
// (push0 lands before push1) and one pop port; exposes its storage for lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push0,
    input  wb_entry_t                   i_entry0,
    input  logic                        i_push1,
    input  wb_entry_t                   i_entry1,
    input  logic                        i_pop,
    output wb_entry_t                   o_head,
    output logic      [PTR_W-1:0]       o_head_ptr,
    output logic      [CNT_W-1:0]       o_count,
    output wb_entry_t [DEPTH-1:0]       o_entries
);

    logic      [PTR_W-1:0] r_rd_ptr;
    logic      [PTR_W-1:0] r_wr_ptr;
    logic      [PTR_W-1:0] w_wr1_ptr;
    logic      [CNT_W-1:0] r_count;
    logic      [CNT_W-1:0] w_count_next;
    wb_entry_t [DEPTH-1:0] r_mem;

    // push1 takes the slot after push0 only when push0 actually writes.
    assign w_wr1_ptr    = r_wr_ptr + PTR_W'(i_push0);
    assign w_count_next = r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
            r_count  <= w_count_next;
        end
    end

    // NOTE: storage is deliberately not reset; nothing reads a slot until
    // the count says it holds a live entry.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_entry0;
        if (i_push1) r_mem[w_wr1_ptr] <= i_entry1;
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_head_ptr = r_rd_ptr;
    assign o_count    = r_count;
    assign o_entries  = r_mem;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: buffers ALU/load results and drains one per cycle into
// the register file write port. Define WB_FORWARD_EN for the pending-write lookup.
module reg_writeback #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int DEPTH  = wb_pkg::WB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    reg_writeback_if.slave            bus,
    output logic [DATA_W-1:0]         wtd,
    output logic [ADDR_W-1:0]         wta,
    output logic                      cnt,
    input  logic [ADDR_W-1:0]         qa,
    output logic                      q_hit,
    output logic [DATA_W-1:0]         q_data,
    output logic [$clog2(DEPTH):0]    pending
);

    import wb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] ROOM_ONE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ROOM_TWO = CNT_W'(DEPTH - 2);

    wb_entry_t             w_mem_entry;
    wb_entry_t             w_alu_entry;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic      [PTR_W-1:0] w_head_ptr;
    logic      [CNT_W-1:0] w_count;
    logic                  w_push_mem;
    logic                  w_push_alu;
    logic                  w_pop;

    logic                  r_cnt;
    logic      [ADDR_W-1:0] r_wta;
    logic      [DATA_W-1:0] r_wtd;

    // Ready looks only at the registered count; a same-cycle pop earns no credit.
    assign bus.mem_ready = (w_count <= ROOM_ONE);
    assign bus.alu_ready = bus.mem_valid ? (w_count <= ROOM_TWO) : (w_count <= ROOM_ONE);

    // Writes to r0 complete their handshake but are never buffered.
    assign w_push_mem = bus.mem_valid && bus.mem_ready && (bus.mem_addr != REG_ZERO);
    assign w_push_alu = bus.alu_valid && bus.alu_ready && (bus.alu_addr != REG_ZERO);
    assign w_pop      = (w_count != '0);

    assign w_mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
    assign w_alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push0    (w_push_mem),
        .i_entry0   (w_mem_entry),
        .i_push1    (w_push_alu),
        .i_entry1   (w_alu_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_head_ptr (w_head_ptr),
        .o_count    (w_count),
        .o_entries  (w_entries)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 1'b0;
            r_wta <= '0;
            r_wtd <= '0;
        end else begin
            r_cnt <= w_pop;
            if (w_pop) begin
                r_wta <= w_head.addr;
                r_wtd <= w_head.data;
            end
        end
    end

    assign cnt     = r_cnt;
    assign wta     = r_wta;
    assign wtd     = r_wtd;
    assign pending = w_count;

`ifdef WB_FORWARD_EN
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    // NOTE: every output of this block is defaulted first so no path
    // through the search can leave a value held, which would infer a latch.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hit = 1'b0;
        w_fwd = '0;
        idx   = '0;
        if (qa != REG_ZERO) begin
            // Oldest first, so the youngest match is the one left standing.
            if (r_cnt && (r_wta == qa)) begin
                w_hit = 1'b1;
                w_fwd = r_wtd;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = w_head_ptr + PTR_W'(i);
                if ((CNT_W'(i) < w_count) && (w_entries[idx].addr == qa)) begin
                    w_hit = 1'b1;
                    w_fwd = w_entries[idx].data;
                end
            end
        end
    end

    assign q_hit  = w_hit;
    assign q_data = w_fwd;
`else
    logic w_unused;

    assign q_hit    = 1'b0;
    assign q_data   = '0;
    assign w_unused = ^{qa, w_entries, w_head_ptr};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: one cyc() call per clock drives both
// channels and compares ready, occupancy and the write port against hand values.
module tb_reg_writeback;

    import wb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] wtd;
    logic [ADDR_W-1:0] wta;
    logic              cnt;
    logic [ADDR_W-1:0] qa;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;
    logic [2:0]        pending;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    int fwd_en;

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .wtd     (wtd),
        .wta     (wta),
        .cnt     (cnt),
        .qa      (qa),
        .q_hit   (q_hit),
        .q_data  (q_data),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1: drive inputs, check readiness, clock once,
    // then check the registered results.
    task automatic cyc(
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic emr, input logic ear,
        input logic [2:0] epend, input logic ecnt, input logic [4:0] ewta, input logic [31:0] ewtd);
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        #1;
        check($sformatf("c%0d mem_ready", n_cyc), 32'(bus.mem_ready), 32'(emr));
        check($sformatf("c%0d alu_ready", n_cyc), 32'(bus.alu_ready), 32'(ear));
        @(posedge clk); #1;
        check($sformatf("c%0d pending", n_cyc), 32'(pending), 32'(epend));
        check($sformatf("c%0d cnt", n_cyc), 32'(cnt), 32'(ecnt));
        check($sformatf("c%0d wta", n_cyc), 32'(wta), 32'(ewta));
        check($sformatf("c%0d wtd", n_cyc), wtd, ewtd);
        n_cyc++;
    endtask

    task automatic idle(input logic [2:0] epend, input logic ecnt, input logic [4:0] ewta, input logic [31:0] ewtd);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, epend, ecnt, ewta, ewtd);
    endtask

    initial begin
`ifdef WB_FORWARD_EN
        fwd_en = 1;
`else
        fwd_en = 0;
`endif
        rst_n = 1'b0;
        qa    = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        #12;
        check("rst cnt", 32'(cnt), 32'd0);
        check("rst pending", 32'(pending), 32'd0);
        check("rst wta", 32'(wta), 32'd0);
        check("rst wtd", wtd, 32'd0);
        check("rst mem_ready", 32'(bus.mem_ready), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // single write: visible for exactly one cycle
        cyc(0, 0, 0, 1, 1, 32'h1, 1, 1, 3'd1, 0, 5'd0, 32'h0);
        idle(3'd0, 1, 5'd1, 32'h1);
        idle(3'd0, 0, 5'd1, 32'h1);

        // dual accept: load result drains first
        cyc(1, 3, 32'hAAAA, 1, 4, 32'h5555, 1, 1, 3'd2, 0, 5'd1, 32'h1);
        idle(3'd1, 1, 5'd3, 32'hAAAA);
        idle(3'd0, 1, 5'd4, 32'h5555);
        idle(3'd0, 0, 5'd4, 32'h5555);

        // r0 handshake completes, nothing written
        cyc(0, 0, 0, 1, 0, 32'h2, 1, 1, 3'd0, 0, 5'd4, 32'h5555);
        idle(3'd0, 0, 5'd4, 32'h5555);

        // backpressure: alu stalls at count 3 while mem_valid is high
        cyc(1, 1, 32'hD1, 1, 2, 32'hD2, 1, 1, 3'd2, 0, 5'd4, 32'h5555);
        cyc(1, 3, 32'hD3, 1, 4, 32'hD4, 1, 1, 3'd3, 1, 5'd1, 32'hD1);
        cyc(1, 5, 32'hD5, 1, 6, 32'hD6, 1, 0, 3'd3, 1, 5'd2, 32'hD2);
        cyc(1, 7, 32'hD7, 1, 6, 32'hD6, 1, 0, 3'd3, 1, 5'd3, 32'hD3);
        cyc(0, 0, 0,      1, 6, 32'hD6, 1, 1, 3'd3, 1, 5'd4, 32'hD4);
        cyc(0, 0, 0,      1, 8, 32'hD8, 1, 1, 3'd3, 1, 5'd5, 32'hD5);
        idle(3'd2, 1, 5'd7, 32'hD7);
        idle(3'd1, 1, 5'd6, 32'hD6);
        idle(3'd0, 1, 5'd8, 32'hD8);
        idle(3'd0, 0, 5'd8, 32'hD8);

        // asynchronous reset with three entries queued
        cyc(1, 9,  32'hE9, 1, 10, 32'hEA, 1, 1, 3'd2, 0, 5'd8, 32'hD8);
        cyc(1, 11, 32'hEB, 1, 12, 32'hEC, 1, 1, 3'd3, 1, 5'd9, 32'hE9);
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid rst cnt", 32'(cnt), 32'd0);
        check("mid rst pending", 32'(pending), 32'd0);
        check("mid rst wta", 32'(wta), 32'd0);
        check("mid rst wtd", wtd, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) idle(3'd0, 0, 5'd0, 32'h0);

        // forwarding: youngest of two pending writes to r5
        cyc(1, 5, 32'h10, 1, 5, 32'h20, 1, 1, 3'd2, 0, 5'd0, 32'h0);
        qa = 5'd5; #1;
        check("fwd fifo hit", 32'(q_hit), 32'(fwd_en));
        check("fwd fifo data", q_data, fwd_en != 0 ? 32'h20 : 32'h0);
        idle(3'd1, 1, 5'd5, 32'h10);
        check("fwd mixed hit", 32'(q_hit), 32'(fwd_en));
        check("fwd mixed data", q_data, fwd_en != 0 ? 32'h20 : 32'h0);
        idle(3'd0, 1, 5'd5, 32'h20);
        check("fwd outreg hit", 32'(q_hit), 32'(fwd_en));
        check("fwd outreg data", q_data, fwd_en != 0 ? 32'h20 : 32'h0);
        qa = 5'd0; #1;
        check("fwd r0 hit", 32'(q_hit), 32'd0);
        qa = 5'd6; #1;
        check("fwd miss hit", 32'(q_hit), 32'd0);
        qa = 5'd5;
        idle(3'd0, 0, 5'd5, 32'h20);
        check("fwd drained hit", 32'(q_hit), 32'd0);
        check("fwd drained data", q_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
